pb_fill_engine: RTL

- Hardware rectangle-fill engine for the 4-bit pixel buffer.
- Sits between the Nios II command PIOs and the pixel buffer write port (wraddress/data/wren), replacing per-pixel software writes.
- Runs on the VGA pixel clock, the same domain as the pixel buffer.
- Accepts one fill command, clips it to the frame, then writes one pixel per cycle in row-major order.

---
 rtl/pb_fill_engine.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pb_fill_engine.sv
// Rectangle-fill engine for the 4-bit pixel buffer: clips one command to the frame and writes one pixel per clock.
// Build option: define FILL_CHECKER_EN to alternate cmd_colour/cmd_colour_alt in a checkerboard on absolute x^y parity.
module pb_fill_engine #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int AW   = 15
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [XW-1:0] cmd_x0,
  input  logic [YW-1:0] cmd_y0,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_h,
  input  logic [3:0]    cmd_colour,
  input  logic [3:0]    cmd_colour_alt,
  output logic [AW-1:0] pb_wraddr,
  output logic [3:0]    pb_data,
  output logic          pb_wren,
  output logic          busy,
  output logic          done
);

  localparam logic [XW:0]   FBW_X = (XW+1)'(FB_W);
  localparam logic [YW:0]   FBH_Y = (YW+1)'(FB_H);
  localparam logic [AW-1:0] FBW_A = AW'(FB_W);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;
  state_t state_q, state_d;

  logic s1_q, s2_q, s3_q, rise;

  logic [XW-1:0] x0_q, x0_d, w_q, w_d, x_q, x_d, x_last_q, x_last_d;
  logic [YW-1:0] y0_q, y0_d, h_q, h_d, y_q, y_d, y_last_q, y_last_d;
  logic [3:0]    colour_q, colour_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] pb_wraddr_q, pb_wraddr_d;
  logic [3:0]    pb_data_q, pb_data_d;
  logic          pb_wren_q, pb_wren_d, busy_q, busy_d, done_q, done_d;

`ifdef FILL_CHECKER_EN
  logic [3:0] alt_q, alt_d;
`else
  logic unused_alt;
  assign unused_alt = &{1'b0, cmd_colour_alt};
`endif

  // start comes straight from a PIO in another clock domain
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= start;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  assign rise = s2_q & ~s3_q;

  // Clip arithmetic is one bit wider than the fields so x0+w cannot wrap.
  logic [XW:0]   x_end, x_lim;
  logic [YW:0]   y_end, y_lim;
  logic [XW-1:0] x_last_c;
  logic [YW-1:0] y_last_c;
  logic [AW-1:0] rb_c;
  logic          clip_empty, at_last;

  assign x_end      = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end      = {1'b0, y0_q} + {1'b0, h_q};
  assign x_lim      = (x_end > FBW_X) ? FBW_X : x_end;
  assign y_lim      = (y_end > FBH_Y) ? FBH_Y : y_end;
  assign x_last_c   = XW'(x_lim - (XW+1)'(1));
  assign y_last_c   = YW'(y_lim - (YW+1)'(1));
  assign rb_c       = AW'(y0_q) * FBW_A;
  assign clip_empty = (w_q == '0) || (h_q == '0) ||
                      ({1'b0, x0_q} >= FBW_X) || ({1'b0, y0_q} >= FBH_Y);
  assign at_last    = (x_q == x_last_q) && (y_q == y_last_q);

  // Position of the pixel to present on the next edge; row base advances by addition only.
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [AW-1:0] pos_row;
  logic [3:0]    pos_colour;

  always_comb begin
    if (state_q == S_CLIP) begin
      pos_x   = x0_q;
      pos_y   = y0_q;
      pos_row = rb_c;
    end else if (x_q == x_last_q) begin
      pos_x   = x0_q;
      pos_y   = y_q + YW'(1);
      pos_row = row_base_q + FBW_A;
    end else begin
      pos_x   = x_q + XW'(1);
      pos_y   = y_q;
      pos_row = row_base_q;
    end
`ifdef FILL_CHECKER_EN
    pos_colour = (pos_x[0] ^ pos_y[0]) ? alt_q : colour_q;
`else
    pos_colour = colour_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rise) state_d = S_CLIP;
      S_CLIP:  state_d = clip_empty ? S_DONE : S_FILL;
      S_FILL:  if (at_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic emit;

  always_comb begin
    emit        = 1'b0;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    colour_d    = colour_q;
`ifdef FILL_CHECKER_EN
    alt_d       = alt_q;
`endif
    x_d         = x_q;
    y_d         = y_q;
    x_last_d    = x_last_q;
    y_last_d    = y_last_q;
    row_base_d  = row_base_q;
    pb_wraddr_d = pb_wraddr_q;
    pb_data_d   = pb_data_q;
    pb_wren_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          x0_d     = cmd_x0;
          y0_d     = cmd_y0;
          w_d      = cmd_w;
          h_d      = cmd_h;
          colour_d = cmd_colour;
`ifdef FILL_CHECKER_EN
          alt_d    = cmd_colour_alt;
`endif
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      S_CLIP: begin
        if (clip_empty) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          x_last_d = x_last_c;
          y_last_d = y_last_c;
          emit     = 1'b1;
        end
      end
      S_FILL: begin
        if (at_last) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          emit = 1'b1;
        end
      end
      default: ;
    endcase
    if (emit) begin
      x_d         = pos_x;
      y_d         = pos_y;
      row_base_d  = pos_row;
      pb_wraddr_d = pos_row + AW'(pos_x);
      pb_data_d   = pos_colour;
      pb_wren_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      colour_q    <= '0;
`ifdef FILL_CHECKER_EN
      alt_q       <= '0;
`endif
      x_q         <= '0;
      y_q         <= '0;
      x_last_q    <= '0;
      y_last_q    <= '0;
      row_base_q  <= '0;
      pb_wraddr_q <= '0;
      pb_data_q   <= '0;
      pb_wren_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      colour_q    <= colour_d;
`ifdef FILL_CHECKER_EN
      alt_q       <= alt_d;
`endif
      x_q         <= x_d;
      y_q         <= y_d;
      x_last_q    <= x_last_d;
      y_last_q    <= y_last_d;
      row_base_q  <= row_base_d;
      pb_wraddr_q <= pb_wraddr_d;
      pb_data_q   <= pb_data_d;
      pb_wren_q   <= pb_wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pb_wraddr = pb_wraddr_q;
  assign pb_data   = pb_data_q;
  assign pb_wren   = pb_wren_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
